// File: rtl/core_pkg.sv
// Shared vector-core types: lane count, operand/id types and the store beat
// carried from the operand collector to the memory interface.
package core_pkg;

  localparam int NrLane   = 4;
  localparam int VrfDataW = 64;
  localparam int InsnIdW  = 4;

  typedef logic [VrfDataW-1:0] vrf_data_t;
  typedef logic [InsnIdW-1:0]  insn_id_t;

  // One wide memory beat: lane l occupies data[l].
  typedef struct packed {
    vrf_data_t [NrLane-1:0] data;
    logic                   last;
  } store_beat_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DONE
  } store_state_e;

endpackage

// File: rtl/store_op_collector_beat_fifo.sv
// Small beat FIFO with synchronous active-high reset.
// STORE_COLLECT_FALLTHROUGH_EN makes an empty FIFO pass its input straight through.
module beat_fifo #(
  parameter int  Depth = 2,
  parameter type T     = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     data_i,
  output logic full_o,
  input  logic pop_i,
  output T     data_o,
  output logic valid_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  T                mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count;
  logic            empty;
  logic            wr_en;
  logic            rd_en;

  assign empty  = (count == '0);
  assign full_o = (count == CntW'(Depth));

`ifdef STORE_COLLECT_FALLTHROUGH_EN
  // A push into an empty FIFO that is popped in the same cycle never lands in storage.
  assign valid_o = !empty || push_i;
  assign data_o  = empty ? data_i : mem[rd_ptr];
  assign wr_en   = push_i && !(empty && pop_i);
  assign rd_en   = pop_i && !empty;
`else
  assign valid_o = !empty;
  assign data_o  = mem[rd_ptr];
  assign wr_en   = push_i;
  assign rd_en   = pop_i;
`endif

  function automatic logic [PtrW-1:0] ptr_incr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_incr(wr_ptr);
      if (rd_en) rd_ptr <= ptr_incr(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale
  // entries are never observed and the array can map onto plain flops or RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/store_op_collector.sv
// Collects one operand per lane into wide store beats for the memory side.
// STORE_COLLECT_FALLTHROUGH_EN (in beat_fifo) removes one cycle of beat latency.
module store_op_collector
  import core_pkg::*;
#(
  parameter int FifoDepth = 2,
  parameter int BeatCntW  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   store_req_valid_i,
  output logic                   store_req_ready_o,
  input  insn_id_t               store_req_id_i,
  input  logic [BeatCntW-1:0]    store_req_beats_i,
  input  logic [NrLane-1:0]      store_op_valid_i,
  output logic [NrLane-1:0]      store_op_ready_o,
  input  vrf_data_t [NrLane-1:0] store_op_i,
  output logic                   mem_data_valid_o,
  input  logic                   mem_data_ready_i,
  output vrf_data_t [NrLane-1:0] mem_data_o,
  output logic                   mem_data_last_o,
  output logic                   store_done_o,
  output insn_id_t               store_done_id_o,
  input  logic                   store_done_gnt_i
);

  store_state_e                     state;
  insn_id_t                         id_q;
  logic [BeatCntW-1:0]              beats_q;
  logic [BeatCntW-1:0]              remaining_q;
  logic [NrLane-1:0][BeatCntW-1:0]  lane_issued_q;
  vrf_data_t [NrLane-1:0]           slot_data_q;
  logic [NrLane-1:0]                slot_full_q;
  logic [NrLane-1:0]                op_fire;
  logic                             in_collect;
  logic                             push;
  logic                             pop;
  logic                             fifo_full;
  logic                             fifo_valid;
  store_beat_t                      push_beat;
  store_beat_t                      head_beat;

  assign in_collect = (state == ST_COLLECT);
  assign pop        = fifo_valid && mem_data_ready_i;
  // A full FIFO always has a valid head, so ready alone tells whether it frees a
  // slot this cycle; this keeps push independent of the fall-through valid path.
  assign push       = in_collect && (&slot_full_q) && (!fifo_full || mem_data_ready_i);

  assign push_beat.data = slot_data_q;
  assign push_beat.last = (remaining_q == BeatCntW'(1));

  always_comb begin
    for (int l = 0; l < NrLane; l++) begin
      store_op_ready_o[l] = in_collect && (!slot_full_q[l] || push)
                            && (lane_issued_q[l] < beats_q);
      op_fire[l]          = store_op_valid_i[l] && store_op_ready_o[l];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_full_q   <= '0;
      lane_issued_q <= '0;
    end else if (store_req_valid_i && store_req_ready_o) begin
      lane_issued_q <= '0;
    end else begin
      for (int l = 0; l < NrLane; l++) begin
        // A refill in the push cycle keeps the slot full for the next beat.
        if (op_fire[l]) begin
          slot_full_q[l]   <= 1'b1;
          lane_issued_q[l] <= lane_issued_q[l] + BeatCntW'(1);
        end else if (push) begin
          slot_full_q[l]   <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int l = 0; l < NrLane; l++) begin
      if (op_fire[l]) slot_data_q[l] <= store_op_i[l];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      id_q        <= '0;
      beats_q     <= '0;
      remaining_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (store_req_valid_i) begin
            id_q        <= store_req_id_i;
            beats_q     <= store_req_beats_i;
            remaining_q <= store_req_beats_i;
            state       <= (store_req_beats_i == '0) ? ST_DONE : ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (push) remaining_q <= remaining_q - BeatCntW'(1);
          if (pop && head_beat.last) state <= ST_DONE;
        end
        ST_DONE: begin
          if (store_done_gnt_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  beat_fifo #(
    .Depth (FifoDepth),
    .T     (store_beat_t)
  ) i_beat_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_beat),
    .full_o  (fifo_full),
    .pop_i   (pop),
    .data_o  (head_beat),
    .valid_o (fifo_valid)
  );

  assign store_req_ready_o = (state == ST_IDLE);
  assign mem_data_valid_o  = fifo_valid;
  assign mem_data_o        = fifo_valid ? head_beat.data : '0;
  assign mem_data_last_o   = fifo_valid && head_beat.last;
  assign store_done_o      = (state == ST_DONE);
  assign store_done_id_o   = id_q;

endmodule

// File: tb/tb_store_op_collector.sv
// Directed self-checking bench for store_op_collector (NrLane=4, 64-bit lanes, FifoDepth=2).
`timescale 1ns/1ps
module tb_store_op_collector;
  import core_pkg::*;

`ifdef STORE_COLLECT_FALLTHROUGH_EN
  localparam int ExtraLat = 0;
`else
  localparam int ExtraLat = 1;
`endif
  localparam int CW = $bits(store_beat_t);

  logic                   clk = 1'b0;
  logic                   rst_i = 1'b0;
  logic                   store_req_valid_i = 1'b0;
  logic                   store_req_ready_o;
  insn_id_t               store_req_id_i = '0;
  logic [15:0]            store_req_beats_i = '0;
  logic [NrLane-1:0]      store_op_valid_i = '0;
  logic [NrLane-1:0]      store_op_ready_o;
  vrf_data_t [NrLane-1:0] store_op_i = '0;
  logic                   mem_data_valid_o;
  logic                   mem_data_ready_i = 1'b0;
  vrf_data_t [NrLane-1:0] mem_data_o;
  logic                   mem_data_last_o;
  logic                   store_done_o;
  insn_id_t               store_done_id_o;
  logic                   store_done_gnt_i = 1'b0;

  store_op_collector #(.FifoDepth(2), .BeatCntW(16)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .store_req_valid_i (store_req_valid_i),
    .store_req_ready_o (store_req_ready_o),
    .store_req_id_i    (store_req_id_i),
    .store_req_beats_i (store_req_beats_i),
    .store_op_valid_i  (store_op_valid_i),
    .store_op_ready_o  (store_op_ready_o),
    .store_op_i        (store_op_i),
    .mem_data_valid_o  (mem_data_valid_o),
    .mem_data_ready_i  (mem_data_ready_i),
    .mem_data_o        (mem_data_o),
    .mem_data_last_o   (mem_data_last_o),
    .store_done_o      (store_done_o),
    .store_done_id_o   (store_done_id_o),
    .store_done_gnt_i  (store_done_gnt_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Lane driver and beat monitor state.
  int          cyc = 0;
  int          c0 = 1 << 30;
  logic [7:0]  tag = '0;
  int          target = 0;
  int          start [NrLane];
  int          sent  [NrLane];
  store_beat_t got_q [$];
  int          got_cyc [$];
  int          done_cyc = -1;

  function automatic vrf_data_t mk(input int b, input int l);
    return {tag, 24'h0, 16'(b), 16'(l)};
  endfunction

  task automatic drive_lanes();
    for (int l = 0; l < NrLane; l++) begin
      store_op_i[l]       = mk(sent[l], l);
      store_op_valid_i[l] = ((cyc - c0) >= start[l]) && (sent[l] < target);
    end
  endtask

  // One clock: observe at negedge, advance drivers just after posedge.
  task automatic step();
    logic [NrLane-1:0] fire;
    store_beat_t       beat;
    @(negedge clk);
    fire = store_op_valid_i & store_op_ready_o;
    if (mem_data_valid_o && mem_data_ready_i) begin
      beat.data = mem_data_o;
      beat.last = mem_data_last_o;
      got_q.push_back(beat);
      got_cyc.push_back(cyc - c0);
    end
    if (store_done_o && done_cyc < 0) done_cyc = cyc - c0;
    @(posedge clk);
    cyc++;
    #1;
    for (int l = 0; l < NrLane; l++) if (fire[l]) sent[l]++;
    drive_lanes();
    #1;
  endtask

  task automatic setup(input logic [7:0] t, input int tgt, input int s0, input int s1,
                       input int s2, input int s3);
    tag = t;
    target = tgt;
    start[0] = s0; start[1] = s1; start[2] = s2; start[3] = s3;
    for (int l = 0; l < NrLane; l++) sent[l] = 0;
    c0 = 1 << 30;
    drive_lanes();
  endtask

  // Request is accepted at the coming edge; the first COLLECT cycle is relative cycle 0.
  task automatic start_req(input insn_id_t id, input int beats);
    store_req_id_i    = id;
    store_req_beats_i = 16'(beats);
    store_req_valid_i = 1'b1;
    c0 = cyc + 1;
    done_cyc = -1;
    got_q.delete();
    got_cyc.delete();
    step();
    store_req_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string t, input insn_id_t exp_id, input int budget);
    int n = 0;
    while (!store_done_o && n < budget) begin
      step();
      n++;
    end
    check({t, " done_seen"}, store_done_o, 1'b1);
    check({t, " done_id"}, store_done_id_o, exp_id);
    store_done_gnt_i = 1'b1;
    step();
    store_done_gnt_i = 1'b0;
    check({t, " back_idle"}, store_req_ready_o, 1'b1);
  endtask

  task automatic check_beats(input string t, input int beats);
    store_beat_t exp;
    check({t, " n_beats"}, got_q.size(), beats);
    for (int b = 0; b < beats && b < got_q.size(); b++) begin
      for (int l = 0; l < NrLane; l++) exp.data[l] = mk(b, l);
      exp.last = (b == beats - 1);
      check($sformatf("%s beat%0d", t, b), got_q[b], exp);
    end
  endtask

  task automatic check_reset_outputs(input string t);
    check({t, " req_ready"}, store_req_ready_o, 1'b1);
    check({t, " op_ready"}, store_op_ready_o, '0);
    check({t, " mem_valid"}, mem_data_valid_o, 1'b0);
    check({t, " mem_last"}, mem_data_last_o, 1'b0);
    check({t, " mem_data"}, mem_data_o, '0);
    check({t, " done"}, store_done_o, 1'b0);
    check({t, " done_id"}, store_done_id_o, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    store_beat_t exp0;
    int          n;

    setup(8'h00, 0, 0, 0, 0, 0);
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    check_reset_outputs("reset");

    // Three beats, all lanes streaming, memory always ready.
    mem_data_ready_i = 1'b1;
    setup(8'h21, 3, 0, 0, 0, 0);
    start_req(4'd5, 3);
    wait_done("t21", 4'd5, 20);
    check_beats("t21", 3);
    check("t21 first_beat_cyc", got_cyc[0], 1 + ExtraLat);
    check("t21 back_to_back", got_cyc[2] - got_cyc[0], 2);
    check("t21 done_after_last", done_cyc, got_cyc[2] + 1);

    // One beat, lane 0 early and lanes 1-3 late; grant held high (ignored until DONE).
    store_done_gnt_i = 1'b1;
    setup(8'h22, 1, 0, 5, 5, 5);
    start_req(4'd2, 1);
    wait_done("t22", 4'd2, 20);
    check_beats("t22", 1);
    check("t22 beat_cyc", got_cyc[0], 6 + ExtraLat);

    // Six beats with memory stalled for ten cycles.
    mem_data_ready_i = 1'b0;
    setup(8'h23, 6, 0, 0, 0, 0);
    start_req(4'd9, 6);
    for (int l = 0; l < NrLane; l++) exp0.data[l] = mk(0, l);
    exp0.last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i >= 3) begin
        check("t23 stall_data", mem_data_o, exp0.data);
        check("t23 stall_last", mem_data_last_o, 1'b0);
      end
    end
    check("t23 op_ready_blocked", store_op_ready_o, '0);
    check("t23 mem_valid", mem_data_valid_o, 1'b1);
    check("t23 lane_accepts", sent[0], 3);
    check("t23 none_popped", got_q.size(), 0);
    mem_data_ready_i = 1'b1;
    wait_done("t23", 4'd9, 40);
    check_beats("t23", 6);

    // Zero beats: done immediately, grant arrives three cycles late.
    setup(8'h24, 0, 0, 0, 0, 0);
    start_req(4'd3, 0);
    check("t24 done_next", store_done_o, 1'b1);
    check("t24 req_ready_low", store_req_ready_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t24 done_held", store_done_o, 1'b1);
      check("t24 id_held", store_done_id_o, 4'd3);
    end
    store_done_gnt_i = 1'b1;
    step();
    store_done_gnt_i = 1'b0;
    check("t24 done_cleared", store_done_o, 1'b0);
    check("t24 no_beats", got_q.size(), 0);

    // Reset after two of five beats, then a fresh single-beat instruction.
    setup(8'h25, 5, 0, 0, 0, 0);
    start_req(4'd6, 5);
    n = 0;
    while (got_q.size() < 2 && n < 30) begin
      step();
      n++;
    end
    check("t25 two_beats_before_reset", got_q.size() >= 2, 1'b1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    setup(8'h25, 0, 0, 0, 0, 0);
    check_reset_outputs("t25 rst");
    got_q.delete();
    done_cyc = -1;
    for (int i = 0; i < 5; i++) step();
    check("t25 no_beats_after_reset", got_q.size(), 0);
    check("t25 no_done_after_reset", done_cyc, -1);
    setup(8'h5b, 1, 0, 0, 0, 0);
    start_req(4'd7, 1);
    wait_done("t25b", 4'd7, 20);
    check_beats("t25b", 1);
    check("t25b beat_cyc", got_cyc[0], 1 + ExtraLat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_op_collector.md
STORE_OP_COLLECTOR -- requirements
Module: store_op_collector

Interface
REQ-001 SHALL have parameter FifoDepth, default 2, beat FIFO entries (>=1).
REQ-002 SHALL have parameter BeatCntW, default 16, width of per-instruction beat count.
REQ-003 SHALL have ports:
- clk_i  input  1  clock; one clock domain.
- rst_i  input  1  reset, synchronous, active-high.
- store_req_valid_i  input  1  new store instruction request.
- store_req_ready_o  output  1  request accepted.
- store_req_id_i  input  insn_id_t  instruction id.
- store_req_beats_i  input  BeatCntW  beats to collect.
- store_op_valid_i  input  NrLane  per-lane operand valid.
- store_op_ready_o  output  NrLane  per-lane operand ready.
- store_op_i  input  NrLane x vrf_data_t  per-lane operands.
- mem_data_valid_o  output  1  wide beat valid.
- mem_data_ready_i  input  1  memory side ready.
- mem_data_o  output  NrLane x vrf_data_t  beat; lane l in slice l.
- mem_data_last_o  output  1  final beat of instruction.
- store_done_o  output  1  instruction complete.
- store_done_id_o  output  insn_id_t  id of completed instruction.
- store_done_gnt_i  input  1  completion acknowledged.

Function
REQ-004 SHALL implement FSM IDLE, COLLECT, DONE.
REQ-005 store_req_ready_o SHALL be 1 only in IDLE; a handshake latches id and beats. beats>0 goes to COLLECT; beats==0 goes to DONE.
REQ-006 SHALL hold one slot per lane; store_op_ready_o[l] = in COLLECT and (slot l empty or push this cycle) and lane beats issued < beats.
- Lanes fill independently.
REQ-007 A push SHALL occur in a cycle where all slots are full and the FIFO is not full (or pops this cycle).
- Concatenates the slots into one FIFO entry.
- Clears the slots unless refilled in that cycle.
- Decrements the remaining counter.
- Tags last when remaining==1.
REQ-008 Throughput SHALL be one beat/cycle sustained with mem_data_ready_i=1 and all lanes valid.
REQ-009 Latency: last lane operand accepted in cycle t -> push in t+1 -> mem_data_valid_o in t+2 (macro off).
REQ-010 mem_data_o and mem_data_last_o SHALL remain stable while mem_data_valid_o=1 and mem_data_ready_i=0.
REQ-011 COLLECT SHALL go to DONE in the cycle the last-tagged beat pops (valid and ready).
REQ-012 In DONE, store_done_o=1 and store_done_id_o=latched id, held until store_done_gnt_i=1. Then IDLE next cycle.
- store_done_gnt_i SHALL be ignored outside DONE.
REQ-013 FIFO full SHALL backpressure the slots only. Operands already in slots SHALL never be dropped or duplicated.
REQ-014 Operand valid in IDLE or DONE SHALL be ignored (ready=0).

Reset
REQ-015 rst_i=1 at an edge SHALL do all of the following:
- FSM to IDLE.
- Slots empty, FIFO empty, counters 0.
- Latched id 0.
REQ-016 Reset values of outputs:
- store_req_ready_o=1 after reset.
- store_op_ready_o=0.
- mem_data_valid_o=0, mem_data_last_o=0, store_done_o=0.
- mem_data_o and store_done_id_o = 0.
REQ-017 Reset mid-instruction SHALL discard partial beats, with no done and no further mem beats.

Configuration
REQ-018 Macro STORE_COLLECT_FALLTHROUGH_EN:
- Defined: when the FIFO is empty, a push SHALL appear on mem_data_o in the same cycle (latency t+1), and may pop that cycle.
- Undefined: pushes are registered; latency per REQ-009.
- Ordering and last/done behaviour identical in both modes.

Structure
REQ-019 insn_id_t, vrf_data_t and NrLane SHALL come from core_pkg.
- SHALL add a store_beat_t struct (data, last) to core_pkg.
REQ-020 The beat FIFO SHALL be a sub-module beat_fifo (Depth, T parameters; synchronous active-high reset).
- Fall-through selected by the macro.

Verification (NrLane=4, vrf_data_t 64-bit, FifoDepth=2)
REQ-021 beats=3; all lanes valid every cycle; ready=1.
- Expect 3 consecutive beats; last only on 3rd.
- store_done_o the cycle after last pop; id matches.
REQ-022 beats=1; lane 0 valid at cycles 0, lanes 1-3 at cycle 5.
- No beat before cycle 7 (macro off).
- mem_data_o = {l3,l2,l1,l0} exactly.
REQ-023 beats=6; mem_data_ready_i=0 for 10 cycles.
- 2 beats buffered, slots full, store_op_ready_o=0.
- After release, all 6 beats in order, none lost.
REQ-024 beats=0 -> store_done_o next cycle, no mem beats.
- gnt held 3 cycles late -> done held stable throughout.
REQ-025 rst_i pulsed after 2 of 5 beats -> outputs at reset values. A new request with id=7, beats=1 then completes normally.
REQ-026 Macro defined, FIFO empty -> beat valid the cycle after the last lane accepts.
